// File: rtl/arb_mux_nto1.sv
// N-input, W-bit arbitrated multiplexer with a registered output stage and
// valid/ready handshakes on every input channel and on the output.
module arb_mux_nto1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1 ? $clog2(NUM_IN) : 1),
  parameter int MODE   = 0
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  logic [SEL_W-1:0]  rr_ptr_reg;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_found;
  logic [WIDTH-1:0]  grant_word;
  logic              slot_free;
  logic              load;
  int                idx;

  assign slot_free = ~out_valid | out_ready;
  assign load      = grant_found & slot_free & ~Reset;
  assign in_ready  = grant & {NUM_IN{slot_free & ~Reset}};

  // Search order starts just past the last winner in round-robin mode,
  // or at channel 0 in fixed-priority mode; the first valid channel wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (MODE == 1)
        idx = k;
      else
        idx = (int'(rr_ptr_reg) + 1 + k) % NUM_IN;
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = SEL_W'(idx);
      end
    end
  end

  // Only the granted (hence valid) channel reaches the register, so X on idle
  // channels cannot leak into out_data.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i])
        grant_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      rr_ptr_reg <= SEL_W'(NUM_IN - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= grant_word;
      out_sel   <= grant_idx;
      if (MODE == 0)
        rr_ptr_reg <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
